// File: rtl/npu_stream_packer.sv
// rtl/npu_stream_packer.sv - packs 64-bit Avalon-ST flits into 256-bit PE rows behind a row FIFO
module npu_stream_packer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [63:0]  st_sink_data,
   input  logic         st_sink_valid,
   output logic         st_sink_ready,
   input  logic         st_sink_startofpacket,
   input  logic         st_sink_endofpacket,
   input  logic [2:0]   st_sink_empty,
   input  logic [31:0]  seq_total_rows,
   output logic [255:0] pe_din,
   output logic         pe_valid_in,
   input  logic         pe_ready_in,
   output logic [31:0]  row_count,
   output logic         pkt_done,
   output logic         err_sop,
   output logic         err_len,
   input  logic         err_clr
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_IN_PKT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [1:0]    flit_idx_q, flit_idx_d;
   logic [255:0]  part_q, part_d;
   logic [31:0]   row_count_q, row_count_d;
   logic          pkt_done_q, pkt_done_d;
   logic          err_sop_q, err_sop_d;
   logic          err_len_q, err_len_d;

   logic [255:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic          fifo_full, fifo_empty;
   logic          accept, push, pop;
   logic          err_sop_set, err_len_set;
   logic [1:0]    lane;
   logic [31:0]   cnt_base;
   logic [63:0]   flit_masked;
   logic [255:0]  row_new;

   assign fifo_full     = (count_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty    = (count_q == '0);
   assign st_sink_ready = !fifo_full;
   assign accept        = st_sink_valid & st_sink_ready;
   assign pop           = !fifo_empty & pe_ready_in;

   assign pe_valid_in = !fifo_empty;
   assign pe_din      = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign row_count   = row_count_q;
   assign pkt_done    = pkt_done_q;
   assign err_sop     = err_sop_q;
   assign err_len     = err_len_q;

   // A SOP flit always restarts at lane 0 with a fresh row count.
   assign lane     = st_sink_startofpacket ? 2'd0 : flit_idx_q;
   assign cnt_base = st_sink_startofpacket ? 32'd0 : row_count_q;

   always_comb begin
      flit_masked = st_sink_data;
      if (st_sink_endofpacket) begin
         for (int b = 0; b < 8; b++) begin
            if (b + int'(st_sink_empty) >= 8) flit_masked[8*b +: 8] = 8'h00;
         end
      end
   end

   // Lanes below the current one keep earlier flits, lanes above are zero.
   always_comb begin
      row_new = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(lane))       row_new[64*k +: 64] = part_q[64*k +: 64];
         else if (k == int'(lane)) row_new[64*k +: 64] = flit_masked;
      end
   end

   always_comb begin
      state_d     = state_q;
      flit_idx_d  = flit_idx_q;
      part_d      = part_q;
      row_count_d = row_count_q;
      pkt_done_d  = 1'b0;
      err_sop_set = 1'b0;
      err_len_set = 1'b0;
      push        = 1'b0;
      if (accept) begin
         if (state_q == S_IDLE && !st_sink_startofpacket) begin
            err_sop_set = 1'b1;
         end else begin
            if (state_q == S_IN_PKT && st_sink_startofpacket && flit_idx_q != 2'd0)
               err_sop_set = 1'b1;
            part_d = row_new;
            if (lane == 2'd3 || st_sink_endofpacket) begin
               push        = 1'b1;
               flit_idx_d  = 2'd0;
               row_count_d = cnt_base + 32'd1;
            end else begin
               flit_idx_d  = lane + 2'd1;
               row_count_d = cnt_base;
            end
            if (st_sink_endofpacket) begin
               state_d    = S_IDLE;
               pkt_done_d = 1'b1;
               if (seq_total_rows != 32'd0 && (cnt_base + 32'd1) != seq_total_rows)
                  err_len_set = 1'b1;
            end else begin
               state_d = S_IN_PKT;
            end
         end
      end
   end

   assign err_sop_d = (err_sop_q & ~err_clr) | err_sop_set;
   assign err_len_d = (err_len_q & ~err_clr) | err_len_set;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= row_new;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         flit_idx_q  <= 2'd0;
         part_q      <= '0;
         row_count_q <= 32'd0;
         pkt_done_q  <= 1'b0;
         err_sop_q   <= 1'b0;
         err_len_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         flit_idx_q  <= flit_idx_d;
         part_q      <= part_d;
         row_count_q <= row_count_d;
         pkt_done_q  <= pkt_done_d;
         err_sop_q   <= err_sop_d;
         err_len_q   <= err_len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: doc/npu_stream_packer.md
NPU_STREAM_PACKER -- requirements
Module: npu_stream_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning number of 256-bit row entries buffered toward the PE array (power of two, 2..16).
REQ-002 clk  in  1  single clock domain; all logic on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 st_sink_data  in  64  Avalon-ST flit from MSGDMA read master.
REQ-005 st_sink_valid  in  1  flit valid.
REQ-006 st_sink_ready  out  1  flit accept; transfer = valid & ready.
REQ-007 st_sink_startofpacket  in  1  first flit of sequence.
REQ-008 st_sink_endofpacket  in  1  last flit of sequence.
REQ-009 st_sink_empty  in  3  count of unused bytes at MS end of the EOP flit.
REQ-010 seq_total_rows  in  32  expected 256-bit rows per packet; 0 disables length check.
REQ-011 pe_din  out  256  assembled row to PE array.
REQ-012 pe_valid_in  out  1  pe_din valid.
REQ-013 pe_ready_in  in  1  PE accepts row; pop = pe_valid_in & pe_ready_in.
REQ-014 row_count  out  32  rows pushed in current packet.
REQ-015 pkt_done  out  1  one-cycle pulse, packet completed.
REQ-016 err_sop  out  1  sticky, framing error.
REQ-017 err_len  out  1  sticky, row-count mismatch at EOP.
REQ-018 err_clr  in  1  synchronous clear of sticky errors.

Function
REQ-019 State machine IDLE / IN_PKT; IDLE on reset.
REQ-020 st_sink_ready = !fifo_full, combinational from registered FIFO count only (no dependency on pe_ready_in).
REQ-021 Accepted flits pack little-endian: flit index k (0..3) writes pe row bits [64k+63:64k]; flit_idx counter 2 bits, wraps 3->0.
REQ-022 Row completes on acceptance of flit_idx==3 or of an EOP flit; completed row pushed into FIFO that same edge, flit_idx -> 0.
REQ-023 EOP with flit_idx<3: unfilled lanes above forced to zero.
REQ-024 EOP flit: the st_sink_empty most-significant bytes of that flit forced to zero in the row.
REQ-025 IDLE + accepted flit with SOP: IN_PKT, row_count -> 0, flit at lane 0.
REQ-026 IDLE + accepted flit without SOP: flit dropped, err_sop set, stay IDLE.
REQ-027 IN_PKT + SOP at flit_idx!=0: partial row discarded, err_sop set, flit restarts lane 0, row_count -> 0.
REQ-028 IN_PKT + SOP at flit_idx==0: treated as new packet, row_count -> 0, no error.
REQ-029 row_count increments on every row push; EOP row included.
REQ-030 Accepted EOP: state -> IDLE; pkt_done pulses next cycle; if seq_total_rows!=0 and final row_count != seq_total_rows, err_len set.
REQ-031 SOP and EOP on same flit: single-flit packet, one row pushed, row_count=1.
REQ-032 FIFO: pe_din = head entry, pe_valid_in = !fifo_empty; pe_din stable while pe_valid_in & !pe_ready_in.
REQ-033 Latency: row on pe_din/pe_valid_in the cycle after its completing flit is accepted, if FIFO was empty.
REQ-034 Simultaneous push and pop: count unchanged, both pointers advance; push blocked when full via REQ-020.
REQ-035 err_clr and a new error in the same cycle: set wins.
REQ-036 Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-037 On rst_n low (any time, incl. mid-row/mid-packet): state IDLE, flit_idx 0, FIFO empty, row_count 0, pkt_done 0, err_sop 0, err_len 0, pe_valid_in 0, pe_din 0 (no valid row), st_sink_ready 1 after reset release; partial rows discarded.

Verification
REQ-038 seq_total_rows=2, 8 flits 0x..01..0x..08 SOP first, EOP last, pe_ready_in=1 -> two rows {f3,f2,f1,f0},{f7,f6,f5,f4}; pkt_done pulse; no errors.
REQ-039 6-flit packet, EOP flit empty=3, seq_total_rows=2 -> second row lanes 2,3 zero, lane 1 top 3 bytes zero; err_len 0.
REQ-040 pe_ready_in=0, 20 flits streamed, FIFO_DEPTH=4 -> st_sink_ready drops after 16th flit; release -> rows in order, no loss/duplication.
REQ-041 SOP at flit_idx=2 -> err_sop=1, partial discarded, next row starts with SOP flit; err_clr -> err_sop 0.
REQ-042 seq_total_rows=3, packet of 2 rows -> err_len=1 at EOP; seq_total_rows=0 same packet -> err_len 0.
REQ-043 rst_n asserted after 2 flits of row -> all outputs at reset values; new SOP packet packs from lane 0 correctly.
